// File: rtl/ezrisc_ctrl_pkg.sv
// Shared encodings for the ezrisc control sequencer: opcodes, ALU functions,
// FSM states and instruction op classes.
package ezrisc_ctrl_pkg;

  localparam logic [4:0] OPC_ADD  = 5'd3;
  localparam logic [4:0] OPC_SUB  = 5'd4;
  localparam logic [4:0] OPC_AND  = 5'd5;
  localparam logic [4:0] OPC_OR   = 5'd6;
  localparam logic [4:0] OPC_ADDI = 5'd11;
  localparam logic [4:0] OPC_ANDI = 5'd12;
  localparam logic [4:0] OPC_ORI  = 5'd13;

  // Encodings match the datapath ALU function select.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    CLS_ITYPE,
    CLS_RTYPE,
    CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/ezrisc_op_decode.sv
// Combinational opcode decoder: maps IR[31:27] to an op class and the ALU
// function the instruction uses in its execute step.
module ezrisc_op_decode
  import ezrisc_ctrl_pkg::*;
#(
  parameter int OPC_W    = 5,
  parameter int ALU_OP_W = 4
) (
  input  logic [OPC_W-1:0]    opcode,
  output op_class_t           op_class,
  output logic [ALU_OP_W-1:0] alu_op
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_op   = '0;
    case (opcode)
      OPC_W'(OPC_ADD):  begin op_class = CLS_RTYPE; alu_op = ALU_OP_W'(ALU_ADD); end
      OPC_W'(OPC_SUB):  begin op_class = CLS_RTYPE; alu_op = ALU_OP_W'(ALU_SUB); end
      OPC_W'(OPC_AND):  begin op_class = CLS_RTYPE; alu_op = ALU_OP_W'(ALU_AND); end
      OPC_W'(OPC_OR):   begin op_class = CLS_RTYPE; alu_op = ALU_OP_W'(ALU_OR);  end
      OPC_W'(OPC_ADDI): begin op_class = CLS_ITYPE; alu_op = ALU_OP_W'(ALU_ADD); end
      OPC_W'(OPC_ANDI): begin op_class = CLS_ITYPE; alu_op = ALU_OP_W'(ALU_AND); end
      OPC_W'(OPC_ORI):  begin op_class = CLS_ITYPE; alu_op = ALU_OP_W'(ALU_OR);  end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// T-state control sequencer for fetch plus single-cycle ALU instructions.
// Outputs are decoded purely from the state and latched op-class registers.
module alu_ctrl_sequencer
  import ezrisc_ctrl_pkg::*;
#(
  parameter int OPC_W    = 5,
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 16,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [OPC_W-1:0]    ir_opcode,
  input  logic                mem_ready,
  output logic                pc_out,
  output logic                mar_in,
  output logic                inc_pc,
  output logic                pc_in,
  output logic                read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                gra,
  output logic                grb,
  output logic                grc,
  output logic                r_in,
  output logic                r_out,
  output logic                y_in,
  output logic                c_out,
  output logic                z_in,
  output logic                z_low_out,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                busy,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  state_t              state_q, state_d;
  op_class_t           cls_q, cls_d;
  logic [ALU_OP_W-1:0] aop_q, aop_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  op_class_t           dec_cls;
  logic [ALU_OP_W-1:0] dec_aop;

  ezrisc_op_decode #(
    .OPC_W    (OPC_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_decode (
    .opcode   (ir_opcode),
    .op_class (dec_cls),
    .alu_op   (dec_aop)
  );

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    aop_d     = aop_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (mem_ready || !MEM_WAIT) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      // IR was loaded at the end of T2, so the opcode is stable here.
      ST_T3: begin
        cls_d   = dec_cls;
        aop_d   = dec_aop;
        state_d = (dec_cls == CLS_ILLEGAL) ? ST_HALT : ST_T4;
      end
      ST_T4:   state_d = ST_T5;
      ST_T5: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = run ? ST_T0 : ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_ITYPE;
      aop_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      aop_q     <= aop_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    pc_out    = 1'b0;
    mar_in    = 1'b0;
    inc_pc    = 1'b0;
    pc_in     = 1'b0;
    read      = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    gra       = 1'b0;
    grb       = 1'b0;
    grc       = 1'b0;
    r_in      = 1'b0;
    r_out     = 1'b0;
    y_in      = 1'b0;
    c_out     = 1'b0;
    z_in      = 1'b0;
    z_low_out = 1'b0;
    alu_op    = '0;
    case (state_q)
      ST_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
        alu_op = ALU_OP_W'(ALU_ADD);
      end
      // Held through memory waits; reloading PC from Z repeatedly is harmless.
      ST_T1: begin
        z_low_out = 1'b1;
        pc_in     = 1'b1;
        read      = 1'b1;
        mdr_in    = 1'b1;
      end
      ST_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      ST_T3: begin
        grb   = 1'b1;
        r_out = 1'b1;
        y_in  = 1'b1;
      end
      ST_T4: begin
        z_in   = 1'b1;
        alu_op = aop_q;
        if (cls_q == CLS_ITYPE) begin
          c_out = 1'b1;
        end else if (cls_q == CLS_RTYPE) begin
          grc   = 1'b1;
          r_out = 1'b1;
        end
      end
      ST_T5: begin
        z_low_out = 1'b1;
        gra       = 1'b1;
        r_in      = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign illegal = (state_q == ST_HALT);
  assign retired = retired_q;

endmodule

// File: doc/alu_ctrl_sequencer.md
# alu_ctrl_sequencer

Synthesizable control-step sequencer that drives the datapath strobes for instruction fetch and single-cycle ALU instructions. It supports both immediate forms (`addi`, `andi`, `ori`) and register forms (`add`, `sub`, `and`, `or`). It runs one T-state per clock, stalls on a memory-ready handshake, counts retired instructions and halts on illegal opcodes. It sits beside `datapath` and connects directly to its control ports.

## Interface
- `OPC_W`, 5: opcode field width (IR[31:27]).
- `ALU_OP_W`, 4: width of `alu_op`.
- `CNT_W`, 16: width of the retired-instruction counter.
- `MEM_WAIT`, 1: 1 = honour `mem_ready`; 0 = treat memory as always ready.

Ports:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `run` in 1: start/continue fetching.
- `ir_opcode` in `OPC_W`: IR[31:27], read from the datapath IR.
- `mem_ready` in 1: read data valid this cycle.
- `pc_out`, `mar_in`, `inc_pc`, `pc_in`, `read`, `mdr_in`, `mdr_out`, `ir_in`, `gra`, `grb`, `grc`, `r_in`, `r_out`, `y_in`, `c_out`, `z_in`, `z_low_out` out 1 each: datapath strobes.
- `alu_op` out `ALU_OP_W`: ALU function.
- `busy` out 1: high in T0–T5.
- `illegal` out 1: sticky illegal-opcode flag.
- `retired` out `CNT_W`: count of completed instructions.

## Operation
States are IDLE, T0, T1, T2, T3, T4, T5 and HALT.
- IDLE: no strobes. Moves to T0 when `run`=1.
- T0: assert `pc_out`, `mar_in`, `inc_pc`, `z_in`; `alu_op`=ADD. Always moves to T1.
- T1: assert `z_low_out`, `pc_in`, `read`, `mdr_in`.
  - Moves to T2 when `mem_ready`=1, or unconditionally if `MEM_WAIT`=0.
  - Otherwise stays in T1 with all four strobes held. Reloading PC from Z while waiting is idempotent.
- T2: assert `mdr_out`, `ir_in`. Always moves to T3.
- T3: assert `grb`, `r_out`, `y_in`.
  - Sample `ir_opcode` into an internal op-class register.
  - If the opcode is illegal, go to HALT and set `illegal`; otherwise go to T4.
- T4: assert `z_in`; `alu_op` is mapped from the op class.
  - I-type: also assert `c_out`.
  - R-type: also assert `grc`, `r_out`.
- T5: assert `z_low_out`, `gra`, `r_in`. Increment `retired`, which wraps modulo 2^`CNT_W`.
  - Go to T0 if `run`=1, else IDLE.
- HALT: no strobes, `busy`=0, `illegal`=1. Left only by reset.

Opcode map:
- ADD 5'd3, SUB 5'd4, AND 5'd5, OR 5'd6, ADDI 5'd11, ANDI 5'd12, ORI 5'd13.
- Every other opcode is illegal.

ALU mapping: AND/ANDI→0000, OR/ORI→0001, ADD/ADDI→0010, SUB→0011.

`alu_op` is 0000 in every state except T0 and T4.

`run` is sampled only in IDLE and T5. Deasserting `run` mid-instruction lets that instruction complete.

## Timing
- Outputs are Moore outputs: decoded from the state and op-class registers only. There is no combinational path from any input to any output.
- One state per clock. An instruction takes 6 cycles when `mem_ready` is high in T1, plus one cycle per T1 wait cycle.
- IR is loaded at the end of T2, so `ir_opcode` is valid throughout T3.
- Reset (`reset_n`=0) is asynchronous. Immediately, regardless of current state:
  - state → IDLE;
  - every strobe, `alu_op`, `busy`, `illegal` and `retired` → 0;
  - the op-class register clears.
- `mem_ready` asserted outside T1 is ignored.
- When a T1 wait and `run` deassertion coincide, the wait completes first; `run` is not sampled until T5.

## Structure
- Package `ezrisc_ctrl_pkg` holds:
  - opcode constants;
  - ALU op constants (And=0000, Or=0001, Add=0010, Sub=0011, matching the datapath ALU);
  - the state enum;
  - the op-class enum (ITYPE, RTYPE, ILLEGAL).
- Sub-module `ezrisc_op_decode` (combinational): opcode → {op class, `alu_op`}.
- Top module: FSM, op-class register, retired counter and output decode.

## Test plan
- ORI R2,R1,0x26 (IR 0x69080026), R1=0x1F, `mem_ready`=1 → strobes follow T0..T5 in 6 cycles, T4 `alu_op`=0001 with `c_out`=1, R2=0x3F, `retired`=1.
- Same instruction with `mem_ready` low for 3 cycles in T1 → T1 lasts 4 cycles with strobes held, instruction takes 9 cycles, PC advances by exactly 1.
- R-type ADD R3,R1,R2 with R1=5, R2=7 → T4 asserts `grc` and `r_out` with `alu_op`=0010 and no `c_out`; R3=12.
- Opcode 5'd31 → HALT entered after T3, `illegal`=1, `busy`=0, all strobes 0 until reset; `retired` unchanged.
- `reset_n` pulled low mid-T4 → all outputs 0 within the same cycle without waiting for a clock edge; `retired`=0; after release with `run`=1, T0 follows on the next edge.
- `run` dropped during T2 → instruction finishes through T5, then IDLE; `retired`=0xFFFF → 0 wraps correctly.
